// File: rtl/arvi_dmem_bus_bridge.sv
// Turns each core data-memory request into one held bus transaction and answers with a single ready pulse.
// Two cycles to ready on a zero-wait slave; the watchdog aborts an unacked access with o_DM_err.
module arvi_dmem_bus_bridge #(
  parameter int XLEN           = 32,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic            i_clk,
  input  logic            i_rst,
  input  logic [XLEN-1:0] i_DM_Wd,
  input  logic [XLEN-1:0] i_DM_Addr,
  input  logic [3:0]      i_DM_byte_en,
  input  logic            i_DM_Wen,
  input  logic            i_DM_MemRead,
  output logic            o_DM_data_ready,
  output logic [XLEN-1:0] o_DM_ReadData,
  output logic            o_DM_err,
  input  logic            i_ack,
  input  logic [31:0]     i_rd_data,
  output logic            o_bus_en,
  output logic            o_wr_en,
  output logic [31:0]     o_wr_data,
  output logic [31:0]     o_addr,
  output logic [3:0]      o_byte_en
);

  typedef enum logic [1:0] {S_IDLE, S_REQ, S_DONE} state_t;

  localparam int CW = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;

  state_t          state_q;
  logic            bus_en_q;
  logic            wr_en_q;
  logic [31:0]     wr_data_q;
  logic [31:0]     addr_q;
  logic [3:0]      byte_en_q;
  logic [XLEN-1:0] rdata_q;
  logic            rdy_q;
  logic            err_q;
  logic            wd_expire;

  generate
    if (TIMEOUT_CYCLES > 0) begin : g_wd
      logic [CW-1:0] cnt_q;

      // Held at zero outside REQ, so every new access starts a fresh count.
      always_ff @(posedge i_clk) begin
        if (i_rst || state_q != S_REQ || i_ack) begin
          cnt_q <= '0;
        end else begin
          cnt_q <= cnt_q + 1'b1;
        end
      end

      assign wd_expire = (state_q == S_REQ) && !i_ack &&
                         (cnt_q == CW'(TIMEOUT_CYCLES - 1));
    end else begin : g_no_wd
      assign wd_expire = 1'b0;
    end
  endgenerate

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q   <= S_IDLE;
      bus_en_q  <= 1'b0;
      wr_en_q   <= 1'b0;
      wr_data_q <= '0;
      addr_q    <= '0;
      byte_en_q <= 4'b0;
      rdata_q   <= '0;
      rdy_q     <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (i_DM_Wen || i_DM_MemRead) begin
            addr_q    <= i_DM_Addr;
            wr_data_q <= i_DM_Wd;
            byte_en_q <= i_DM_byte_en;
            wr_en_q   <= i_DM_Wen;
            bus_en_q  <= 1'b1;
            state_q   <= S_REQ;
          end
        end
        S_REQ: begin
          // Ack takes priority over a watchdog expiry in the same cycle.
          if (i_ack) begin
            bus_en_q <= 1'b0;
            wr_en_q  <= 1'b0;
            rdata_q  <= wr_en_q ? '0 : i_rd_data;
            rdy_q    <= 1'b1;
            state_q  <= S_DONE;
          end else if (wd_expire) begin
            bus_en_q <= 1'b0;
            wr_en_q  <= 1'b0;
            rdata_q  <= '0;
            err_q    <= 1'b1;
            rdy_q    <= 1'b1;
            state_q  <= S_DONE;
          end
        end
        S_DONE: begin
          // The core still shows the finished request here; ignoring it avoids a duplicate issue.
          rdy_q   <= 1'b0;
          err_q   <= 1'b0;
          state_q <= S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign o_bus_en        = bus_en_q;
  assign o_wr_en         = wr_en_q;
  assign o_wr_data       = wr_data_q;
  assign o_addr          = addr_q;
  assign o_byte_en       = byte_en_q;
  assign o_DM_ReadData   = rdata_q;
  assign o_DM_data_ready = rdy_q;
  assign o_DM_err        = err_q;

endmodule

// File: tb/tb_arvi_dmem_bus_bridge.sv
// Bench for arvi_dmem_bus_bridge: directed and random accesses on a default instance and one with a 4-cycle watchdog.
module tb_arvi_dmem_bus_bridge;

  logic        clk = 1'b0;
  logic        rst;
  bit          sel;
  logic        dm_wen, dm_ren;
  logic [31:0] dm_addr, dm_wd, rd_data;
  logic [3:0]  dm_be;
  logic        ack;

  int n_chk  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  logic        rdy0, err0, ben0, wen0, rdy1, err1, ben1, wen1;
  logic [31:0] rd0, wd0, ad0, rd1, wd1, ad1;
  logic [3:0]  be0, be1;

  arvi_dmem_bus_bridge #(.XLEN(32), .TIMEOUT_CYCLES(255)) dut (
    .i_clk(clk), .i_rst(rst),
    .i_DM_Wd(dm_wd), .i_DM_Addr(dm_addr), .i_DM_byte_en(dm_be),
    .i_DM_Wen(dm_wen & !sel), .i_DM_MemRead(dm_ren & !sel),
    .o_DM_data_ready(rdy0), .o_DM_ReadData(rd0), .o_DM_err(err0),
    .i_ack(ack & !sel), .i_rd_data(rd_data),
    .o_bus_en(ben0), .o_wr_en(wen0), .o_wr_data(wd0), .o_addr(ad0), .o_byte_en(be0)
  );

  arvi_dmem_bus_bridge #(.XLEN(32), .TIMEOUT_CYCLES(4)) dut_wd (
    .i_clk(clk), .i_rst(rst),
    .i_DM_Wd(dm_wd), .i_DM_Addr(dm_addr), .i_DM_byte_en(dm_be),
    .i_DM_Wen(dm_wen & sel), .i_DM_MemRead(dm_ren & sel),
    .o_DM_data_ready(rdy1), .o_DM_ReadData(rd1), .o_DM_err(err1),
    .i_ack(ack & sel), .i_rd_data(rd_data),
    .o_bus_en(ben1), .o_wr_en(wen1), .o_wr_data(wd1), .o_addr(ad1), .o_byte_en(be1)
  );

  wire        o_rdy  = sel ? rdy1 : rdy0;
  wire        o_err  = sel ? err1 : err0;
  wire        o_ben  = sel ? ben1 : ben0;
  wire        o_wen  = sel ? wen1 : wen0;
  wire [31:0] o_rd   = sel ? rd1  : rd0;
  wire [31:0] o_wd   = sel ? wd1  : wd0;
  wire [31:0] o_ad   = sel ? ad1  : ad0;
  wire [3:0]  o_be   = sel ? be1  : be0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic drop_req();
    dm_wen = 1'b0;
    dm_ren = 1'b0;
  endtask

  task automatic check_idle_zero(input string tag);
    check({tag, "_bus_en"}, o_ben, 0);
    check({tag, "_wr_en"},  o_wen, 0);
    check({tag, "_addr"},   o_ad,  0);
    check({tag, "_wdata"},  o_wd,  0);
    check({tag, "_be"},     o_be,  0);
    check({tag, "_ready"},  o_rdy, 0);
    check({tag, "_err"},    o_err, 0);
    check({tag, "_rdata"},  o_rd,  0);
  endtask

  // Expectations follow the access rules: a write wins over a read, the bus holds for
  // ack_at+1 cycles unless the watchdog fires first, and ready/err last exactly one cycle.
  task automatic access(input bit wen, input bit ren, input logic [31:0] addr,
                        input logic [31:0] wd, input logic [3:0] be, input logic [31:0] rdat,
                        input int ack_at, input bit hold, input bit withdraw);
    int          to;
    bit          tmo;
    int          nreq;
    bit          is_wr;
    logic [31:0] exp_rd;
    to     = sel ? 4 : 255;
    is_wr  = wen;
    tmo    = (ack_at < 0) || (ack_at >= to);
    nreq   = tmo ? to : ack_at + 1;
    exp_rd = (tmo || is_wr) ? 32'h0 : rdat;
    dm_wen = wen; dm_ren = ren; dm_addr = addr; dm_wd = wd; dm_be = be;
    for (int c = 0; c < nreq; c++) begin
      @(negedge clk);
      check("req_bus_en", o_ben, 1);
      check("req_wr_en",  o_wen, is_wr);
      check("req_addr",   o_ad,  addr);
      check("req_wdata",  o_wd,  wd);
      check("req_be",     o_be,  be);
      check("req_ready",  o_rdy, 0);
      if (withdraw) drop_req();
      ack     = (c == ack_at);
      rd_data = (c == ack_at) ? rdat : $urandom;
    end
    @(negedge clk);
    ack = 1'b0;
    check("done_ready",  o_rdy, 1);
    check("done_err",    o_err, tmo);
    check("done_rdata",  o_rd,  exp_rd);
    check("done_bus_en", o_ben, 0);
    check("done_wr_en",  o_wen, 0);
    if (!hold) drop_req();
    @(negedge clk);
    check("post_ready",  o_rdy, 0);
    check("post_err",    o_err, 0);
    check("post_bus_en", o_ben, 0);
    drop_req();
  endtask

  task automatic do_reset();
    rst = 1'b1;
    drop_req();
    ack = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    sel = 1'b0; rst = 1'b1; ack = 1'b0; rd_data = '0;
    dm_wen = 1'b0; dm_ren = 1'b0; dm_addr = '0; dm_wd = '0; dm_be = '0;
    @(negedge clk);
    do_reset();
    check_idle_zero("reset");

    // Default instance: zero-wait read, 5-cycle write, simultaneous Wen/MemRead.
    access(0, 1, 32'h0000_0040, 32'h5555_AAAA, 4'hF, 32'hDEADBEEF, 0, 0, 0);
    access(1, 0, 32'h0000_0100, 32'h1234_5678, 4'b0011, 32'hCAFE_F00D, 4, 0, 0);
    access(1, 1, 32'h0000_0200, 32'hA5A5_0001, 4'b1100, 32'h0BAD_0BAD, 2, 0, 0);
    // Request held through DONE, then a new read issued straight after.
    access(0, 1, 32'h0000_0300, 32'h0, 4'hF, 32'h1111_2222, 1, 1, 0);
    access(0, 1, 32'h0000_0304, 32'h0, 4'hF, 32'h3333_4444, 0, 0, 0);
    // Core withdraws mid-access; the transaction still completes.
    access(0, 1, 32'h0000_0400, 32'h0, 4'h1, 32'h7777_8888, 3, 0, 1);

    // Stray ack while idle.
    ack = 1'b1;
    repeat (2) begin
      @(negedge clk);
      check("stray_ack_ready",  o_rdy, 0);
      check("stray_ack_bus_en", o_ben, 0);
    end
    ack = 1'b0;

    // Reset during REQ abandons the access without a pulse.
    dm_ren = 1'b1; dm_addr = 32'h0000_0500; dm_wd = 32'h9; dm_be = 4'hF;
    @(negedge clk);
    check("rstreq_bus_en", o_ben, 1);
    @(negedge clk);
    rst = 1'b1;
    drop_req();
    @(negedge clk);
    rst = 1'b0;
    check_idle_zero("rst_mid_req");
    repeat (3) begin
      @(negedge clk);
      check("rst_after_ready",  o_rdy, 0);
      check("rst_after_bus_en", o_ben, 0);
    end

    for (int i = 0; i < 25; i++) begin
      int k;
      k = $urandom_range(2);
      access(k != 0, k != 1, $urandom, $urandom, 4'($urandom), $urandom,
             $urandom_range(6), 1'($urandom), 1'($urandom));
    end

    // Watchdog instance: plain timeout, ack on the expiry cycle, ack just before it.
    sel = 1'b1;
    do_reset();
    check_idle_zero("reset_wd");
    access(0, 1, 32'h0000_0600, 32'h0, 4'hF, 32'hFFFF_FFFF, -1, 0, 0);
    access(0, 1, 32'h0000_0604, 32'h0, 4'hF, 32'h0123_4567, 3, 0, 0);
    access(1, 0, 32'h0000_0608, 32'h89AB_CDEF, 4'h3, 32'h0, -1, 0, 0);
    access(0, 1, 32'h0000_060C, 32'h0, 4'hF, 32'h7654_3210, 2, 0, 0);

    for (int i = 0; i < 25; i++) begin
      int k;
      int a;
      k = $urandom_range(2);
      a = $urandom_range(7) - 1;
      access(k != 0, k != 1, $urandom, $urandom, 4'($urandom), $urandom,
             a, 1'($urandom), 1'($urandom));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
